// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: accepts a byte, drives start/data/parity/stop
// bits onto a registered TX line, stepping an external serializer once per baud tick.
module uart_tx_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic                  ser_data,
  output logic                  ser_load,
  output logic                  ser_en,
  output logic                  data_ack,
  output logic                  tx_out,
  output logic                  busy
);

  localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic               tx_q, tx_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic               stop_cnt_q, stop_cnt_d;
  logic               parity_q, parity_d;
  logic               par_en_q, par_en_d;
  logic               accept_c;
  logic               shift_c;

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      parity_q   <= 1'b0;
      par_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      parity_q   <= parity_d;
      par_en_q   <= par_en_d;
    end
  end

  // Next-state logic; every advance is qualified by the baud tick
  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    parity_d   = parity_q;
    par_en_d   = par_en_q;
    accept_c   = 1'b0;
    shift_c    = 1'b0;

    if (tick) begin
      unique case (state_q)
        IDLE: begin
          tx_d     = 1'b1;
          accept_c = data_valid;
        end
        START: begin
          tx_d    = ser_data;
          shift_c = 1'b1;
          state_d = DATA;
        end
        DATA: begin
          if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
            stop_cnt_d = 1'b0;
            if (par_en_q) begin
              tx_d    = parity_q;
              state_d = PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = STOP;
            end
          end else begin
            tx_d      = ser_data;
            shift_c   = 1'b1;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
        PARITY: begin
          tx_d    = 1'b1;
          state_d = STOP;
        end
        STOP: begin
          if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
            if (data_valid) accept_c = 1'b1;
            else            state_d  = IDLE;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
        default: begin
          tx_d    = 1'b1;
          state_d = IDLE;
        end
      endcase
    end

    // Accept overrides: capture frame options and emit the start bit
    if (accept_c) begin
      tx_d      = 1'b0;
      bit_cnt_d = '0;
      state_d   = START;
      par_en_d  = par_en;
      parity_d  = par_typ ? ~^p_data : ^p_data;
    end

    busy_d = (state_d != IDLE);
  end

  assign ser_load = accept_c & ~rst;
  assign data_ack = accept_c & ~rst;
  assign ser_en   = shift_c & ~rst;
  assign tx_out   = tx_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: one-stop and two-stop instances share stimulus,
// each paired with a small LSB-first shift-register serializer model.
module tb_uart_tx_ctrl;

  logic       clk = 1'b0;
  logic       rst, tick, data_valid, par_en, par_typ;
  logic [7:0] p_data;

  logic       ser_load, ser_en, data_ack, tx_out, busy, ser_data;
  logic       ser_load2, ser_en2, data_ack2, tx_out2, busy2, ser_data2;
  logic [7:0] sreg, sreg2;

  int n_cmp = 0;
  int n_bad = 0;
  int period = 1;
  int phase = 0;
  int ack_cnt = 0;
  int ack2_cnt = 0;
  int sen_cnt = 0;
  logic cap [0:63];
  logic bcap [0:63];

  uart_tx_ctrl #(.DATA_WIDTH(8), .STOP_BITS(1)) dut (
    .clk(clk), .rst(rst), .tick(tick), .p_data(p_data), .data_valid(data_valid),
    .par_en(par_en), .par_typ(par_typ), .ser_data(ser_data), .ser_load(ser_load),
    .ser_en(ser_en), .data_ack(data_ack), .tx_out(tx_out), .busy(busy)
  );

  uart_tx_ctrl #(.DATA_WIDTH(8), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .tick(tick), .p_data(p_data), .data_valid(data_valid),
    .par_en(par_en), .par_typ(par_typ), .ser_data(ser_data2), .ser_load(ser_load2),
    .ser_en(ser_en2), .data_ack(data_ack2), .tx_out(tx_out2), .busy(busy2)
  );

  always #5 clk = ~clk;

  // Serializer models: load on ser_load, shift right with zero fill on ser_en
  always @(posedge clk) begin
    if (ser_load) sreg <= p_data;
    else if (ser_en) sreg <= {1'b0, sreg[7:1]};
    if (ser_load2) sreg2 <= p_data;
    else if (ser_en2) sreg2 <= {1'b0, sreg2[7:1]};
  end
  assign ser_data  = sreg[0];
  assign ser_data2 = sreg2[0];

  // Pulse counters sampled mid-cycle
  always @(negedge clk) begin
    if (data_ack === 1'b1)  ack_cnt  = ack_cnt + 1;
    if (data_ack2 === 1'b1) ack2_cnt = ack2_cnt + 1;
    if (ser_en === 1'b1)    sen_cnt  = sen_cnt + 1;
  end

  task automatic step();
    @(posedge clk); #1;
    phase = (phase + 1) % period;
    tick  = (phase == 0);
  endtask

  task automatic idle(input int n);
    period = 1; phase = 0; tick = 1'b1; data_valid = 1'b0;
    repeat (n) step();
  endtask

  // Launch one frame from IDLE and record tx_out/busy after each edge from the accept edge
  task automatic frame(input logic [7:0] d, input logic pe, input logic pt, input int per, input int n);
    period = per; phase = 0; tick = 1'b1;
    p_data = d; par_en = pe; par_typ = pt; data_valid = 1'b1;
    step();
    data_valid = 1'b0; p_data = ~d; par_en = ~pe; par_typ = ~pt;
    cap[0] = tx_out; bcap[0] = busy;
    for (int i = 1; i < n; i++) begin
      step();
      cap[i] = tx_out; bcap[i] = busy;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; tick = 1'b1; data_valid = 1'b1; p_data = 8'h55; par_en = 1'b0; par_typ = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    if (tx_out !== 1'b1) begin n_bad++; $display("FAIL reset_tx got=%b exp=1", tx_out); end n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end n_cmp++;
    if (ser_load !== 1'b0) begin n_bad++; $display("FAIL reset_ser_load got=%b exp=0", ser_load); end n_cmp++;
    if (data_ack !== 1'b0) begin n_bad++; $display("FAIL reset_data_ack got=%b exp=0", data_ack); end n_cmp++;
    if (ser_en !== 1'b0) begin n_bad++; $display("FAIL reset_ser_en got=%b exp=0", ser_en); end n_cmp++;
    if (tx_out2 !== 1'b1) begin n_bad++; $display("FAIL reset_tx2 got=%b exp=1", tx_out2); end n_cmp++;
    if (busy2 !== 1'b0) begin n_bad++; $display("FAIL reset_busy2 got=%b exp=0", busy2); end n_cmp++;
    rst = 1'b0; data_valid = 1'b0;
    idle(2);
  endtask

  task automatic test_basic();
    logic [11:0] exp_bits;
    int ack0, sen0;
    exp_bits = {3'b111, 8'hA5, 1'b0};
    ack0 = ack_cnt; sen0 = sen_cnt;
    frame(8'hA5, 1'b0, 1'b0, 1, 12);
    for (int i = 0; i < 12; i++) begin
      if (cap[i] !== exp_bits[i]) begin n_bad++; $display("FAIL basic_tx[%0d] got=%b exp=%b", i, cap[i], exp_bits[i]); end n_cmp++;
      if (bcap[i] !== (i < 10)) begin n_bad++; $display("FAIL basic_busy[%0d] got=%b exp=%b", i, bcap[i], (i < 10)); end n_cmp++;
    end
    if (ack_cnt - ack0 !== 1) begin n_bad++; $display("FAIL basic_acks got=%0d exp=1", ack_cnt - ack0); end n_cmp++;
    if (sen_cnt - sen0 !== 8) begin n_bad++; $display("FAIL basic_ser_en got=%0d exp=8", sen_cnt - sen0); end n_cmp++;
    idle(4);
  endtask

  task automatic test_parity_slow();
    logic [11:0] exp_bits;
    int ack0;
    exp_bits = {2'b11, 1'b0, 8'hA5, 1'b0};
    ack0 = ack_cnt;
    frame(8'hA5, 1'b1, 1'b0, 4, 48);
    for (int i = 0; i < 48; i++) begin
      if (cap[i] !== exp_bits[i/4]) begin n_bad++; $display("FAIL par_tx[%0d] got=%b exp=%b", i, cap[i], exp_bits[i/4]); end n_cmp++;
      if (bcap[i] !== (i < 44)) begin n_bad++; $display("FAIL par_busy[%0d] got=%b exp=%b", i, bcap[i], (i < 44)); end n_cmp++;
    end
    if (ack_cnt - ack0 !== 1) begin n_bad++; $display("FAIL par_acks got=%0d exp=1", ack_cnt - ack0); end n_cmp++;
    idle(4);
  endtask

  task automatic test_parity_values();
    frame(8'h00, 1'b1, 1'b1, 1, 12);
    if (cap[1] !== 1'b0) begin n_bad++; $display("FAIL odd00_d0 got=%b exp=0", cap[1]); end n_cmp++;
    if (cap[9] !== 1'b1) begin n_bad++; $display("FAIL odd00_parity got=%b exp=1", cap[9]); end n_cmp++;
    if (cap[10] !== 1'b1) begin n_bad++; $display("FAIL odd00_stop got=%b exp=1", cap[10]); end n_cmp++;
    if (bcap[10] !== 1'b1) begin n_bad++; $display("FAIL odd00_busy10 got=%b exp=1", bcap[10]); end n_cmp++;
    if (bcap[11] !== 1'b0) begin n_bad++; $display("FAIL odd00_busy11 got=%b exp=0", bcap[11]); end n_cmp++;
    idle(3);
    frame(8'hFF, 1'b1, 1'b0, 1, 12);
    if (cap[8] !== 1'b1) begin n_bad++; $display("FAIL evenFF_d7 got=%b exp=1", cap[8]); end n_cmp++;
    if (cap[9] !== 1'b0) begin n_bad++; $display("FAIL evenFF_parity got=%b exp=0", cap[9]); end n_cmp++;
    if (cap[10] !== 1'b1) begin n_bad++; $display("FAIL evenFF_stop got=%b exp=1", cap[10]); end n_cmp++;
    idle(3);
  endtask

  task automatic test_back_to_back();
    logic [23:0] exp_bits;
    logic        akc [0:23];
    logic        tx1 [0:23];
    int          acks, ack0;
    exp_bits = {2'b11, 2'b11, 8'hC3, 1'b0, 2'b11, 8'h3C, 1'b0};
    period = 1; phase = 0; tick = 1'b1;
    p_data = 8'h3C; par_en = 1'b0; par_typ = 1'b0; data_valid = 1'b1;
    acks = 0; ack0 = ack2_cnt;
    for (int i = 0; i < 24; i++) begin
      #1;
      akc[i] = data_ack2;
      if (data_ack2 === 1'b1) acks++;
      @(posedge clk); #1;
      cap[i] = tx_out2; bcap[i] = busy2; tx1[i] = tx_out;
      if (acks == 1) p_data = 8'hC3;
      if (acks >= 2) data_valid = 1'b0;
    end
    for (int i = 0; i < 24; i++) begin
      if (cap[i] !== exp_bits[i]) begin n_bad++; $display("FAIL b2b_tx[%0d] got=%b exp=%b", i, cap[i], exp_bits[i]); end n_cmp++;
      if (bcap[i] !== (i < 22)) begin n_bad++; $display("FAIL b2b_busy[%0d] got=%b exp=%b", i, bcap[i], (i < 22)); end n_cmp++;
      if (akc[i] !== (i == 0 || i == 11)) begin n_bad++; $display("FAIL b2b_ack[%0d] got=%b exp=%b", i, akc[i], (i == 0 || i == 11)); end n_cmp++;
    end
    if (ack2_cnt - ack0 !== 2) begin n_bad++; $display("FAIL b2b_acks got=%0d exp=2", ack2_cnt - ack0); end n_cmp++;
    if (tx1[9] !== 1'b1) begin n_bad++; $display("FAIL b2b1_stop got=%b exp=1", tx1[9]); end n_cmp++;
    if (tx1[10] !== 1'b0) begin n_bad++; $display("FAIL b2b1_start got=%b exp=0", tx1[10]); end n_cmp++;
    if (tx1[11] !== 1'b1) begin n_bad++; $display("FAIL b2b1_d0 got=%b exp=1", tx1[11]); end n_cmp++;
    idle(6);
  endtask

  task automatic test_reset_mid();
    logic [11:0] exp_bits;
    int ack0;
    exp_bits = {3'b111, 8'h5A, 1'b0};
    ack0 = ack_cnt;
    period = 1; phase = 0; tick = 1'b1;
    p_data = 8'hA5; par_en = 1'b0; par_typ = 1'b0; data_valid = 1'b1;
    @(posedge clk); #1;
    data_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    if (tx_out !== 1'b0) begin n_bad++; $display("FAIL rmid_bit3 got=%b exp=0", tx_out); end n_cmp++;
    rst = 1'b1; data_valid = 1'b1;
    #1;
    if (data_ack !== 1'b0) begin n_bad++; $display("FAIL rmid_ack got=%b exp=0", data_ack); end n_cmp++;
    if (ser_load !== 1'b0) begin n_bad++; $display("FAIL rmid_load got=%b exp=0", ser_load); end n_cmp++;
    if (ser_en !== 1'b0) begin n_bad++; $display("FAIL rmid_ser_en got=%b exp=0", ser_en); end n_cmp++;
    @(posedge clk); #1;
    if (tx_out !== 1'b1) begin n_bad++; $display("FAIL rmid_tx got=%b exp=1", tx_out); end n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy got=%b exp=0", busy); end n_cmp++;
    if (busy2 !== 1'b0) begin n_bad++; $display("FAIL rmid_busy2 got=%b exp=0", busy2); end n_cmp++;
    rst = 1'b0; data_valid = 1'b0;
    idle(2);
    if (ack_cnt - ack0 !== 1) begin n_bad++; $display("FAIL rmid_acks got=%0d exp=1", ack_cnt - ack0); end n_cmp++;
    frame(8'h5A, 1'b0, 1'b0, 1, 12);
    for (int i = 0; i < 12; i++) begin
      if (cap[i] !== exp_bits[i]) begin n_bad++; $display("FAIL rmid_new_tx[%0d] got=%b exp=%b", i, cap[i], exp_bits[i]); end n_cmp++;
    end
    idle(3);
  endtask

  task automatic test_tick_wait();
    int ack0;
    ack0 = ack_cnt;
    tick = 1'b0; p_data = 8'h81; par_en = 1'b0; par_typ = 1'b0; data_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (data_ack !== 1'b0) begin n_bad++; $display("FAIL twait_ack[%0d] got=%b exp=0", i, data_ack); end n_cmp++;
      if (ser_load !== 1'b0) begin n_bad++; $display("FAIL twait_load[%0d] got=%b exp=0", i, ser_load); end n_cmp++;
      @(posedge clk); #1;
      if (tx_out !== 1'b1) begin n_bad++; $display("FAIL twait_tx[%0d] got=%b exp=1", i, tx_out); end n_cmp++;
    end
    tick = 1'b1;
    #1;
    if (data_ack !== 1'b1) begin n_bad++; $display("FAIL twait_accept_ack got=%b exp=1", data_ack); end n_cmp++;
    if (ser_load !== 1'b1) begin n_bad++; $display("FAIL twait_accept_load got=%b exp=1", ser_load); end n_cmp++;
    @(posedge clk); #1;
    if (tx_out !== 1'b0) begin n_bad++; $display("FAIL twait_start got=%b exp=0", tx_out); end n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL twait_busy got=%b exp=1", busy); end n_cmp++;
    data_valid = 1'b0; tick = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (ser_en !== 1'b0) begin n_bad++; $display("FAIL twait_hold_en[%0d] got=%b exp=0", i, ser_en); end n_cmp++;
      @(posedge clk); #1;
      if (tx_out !== 1'b0) begin n_bad++; $display("FAIL twait_hold_tx[%0d] got=%b exp=0", i, tx_out); end n_cmp++;
    end
    tick = 1'b1;
    @(posedge clk); #1;
    if (tx_out !== 1'b1) begin n_bad++; $display("FAIL twait_d0 got=%b exp=1", tx_out); end n_cmp++;
    idle(14);
    if (ack_cnt - ack0 !== 1) begin n_bad++; $display("FAIL twait_acks got=%0d exp=1", ack_cnt - ack0); end n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL twait_end_busy got=%b exp=0", busy); end n_cmp++;
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; data_valid = 1'b0; par_en = 1'b0; par_typ = 1'b0; p_data = 8'h00;
    test_reset();
    test_basic();
    test_parity_slow();
    test_parity_values();
    test_back_to_back();
    test_reset_mid();
    test_tick_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
